// File: rtl/decoder_code_sequencer_if.sv
// Control/status bundle between a sequencer user (master) and decoder_code_sequencer (slave).
interface decoder_code_sequencer_if #(
  parameter int unsigned DIV_W = 8
);
  logic             start;
  logic             stop;
  logic             dir;
  logic             load;
  logic [1:0]       load_val;
  logic [DIV_W-1:0] div;
  logic [1:0]       code;
  logic             step;
  logic             wrap;
  logic             busy;

  modport master (
    output start, stop, dir, load, load_val, div,
    input  code, step, wrap, busy
  );

  modport slave (
    input  start, stop, dir, load, load_val, div,
    output code, step, wrap, busy
  );
endinterface

// File: rtl/decoder_code_sequencer.sv
// Prescaled 2-bit up/down code stepper feeding a downstream 2-to-4 decoder.
// All outputs come straight from flops.
module decoder_code_sequencer #(
  parameter int unsigned DIV_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  decoder_code_sequencer_if.slave  bus
);

  localparam int unsigned CODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [CODE_W-1:0] code_q,  code_d;
  logic              step_q,  step_d;
  logic              wrap_q,  wrap_d;
  logic              busy_q,  busy_d;
  logic              terminal_c;

  // Magnitude test so a shrinking divisor never forces a full counter wrap.
  assign terminal_c = (presc_q >= bus.div);

  // Next-state, prescaler, code and pulse generation.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    code_d  = code_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (!bus.load) begin
          if (terminal_c) begin
            presc_d = '0;
            step_d  = 1'b1;
            if (bus.dir) begin
              code_d = code_q - CODE_W'(1);
              wrap_d = (code_q == '0);
            end else begin
              code_d = code_q + CODE_W'(1);
              wrap_d = (code_q == '1);
            end
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
      end
    endcase

    // Load overrides any coincident step but leaves the state transition intact.
    if (bus.load) begin
      code_d  = bus.load_val;
      presc_d = '0;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
    end

    busy_d = (state_d == RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      code_q  <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      code_q  <= code_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.code = code_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_decoder_code_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a reference model.
module tb_decoder_code_sequencer;

  localparam int unsigned DIV_W = 8;

  logic clk;
  logic rst_n;

  decoder_code_sequencer_if #(.DIV_W(DIV_W)) bus ();

  decoder_code_sequencer #(.DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: running flag, cycles elapsed in the current period, code as an integer.
  bit m_run;
  int m_cnt;
  int m_code;
  bit m_step;
  bit m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run  = 1'b0;
    m_cnt  = 0;
    m_code = 0;
    m_step = 1'b0;
    m_wrap = 1'b0;
  endfunction

  function automatic void model_edge();
    int nxt;
    m_step = 1'b0;
    m_wrap = 1'b0;
    if (!m_run) begin
      if (bus.start && !bus.stop) begin
        m_run = 1'b1;
        m_cnt = 0;
      end
    end else if (bus.stop) begin
      m_run = 1'b0;
    end else if (!bus.load) begin
      if (m_cnt >= int'(bus.div)) begin
        nxt    = m_code + (bus.dir ? -1 : 1);
        m_wrap = (nxt < 0) || (nxt > 3);
        m_code = (nxt + 4) % 4;
        m_step = 1'b1;
        m_cnt  = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (bus.load) begin
      m_code = int'(bus.load_val);
      m_cnt  = 0;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".code"}, 32'(bus.code), 32'(m_code));
    check({tag, ".step"}, 32'(bus.step), 32'(m_step));
    check({tag, ".wrap"}, 32'(bus.wrap), 32'(m_wrap));
    check({tag, ".busy"}, 32'(bus.busy), 32'(m_run));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit s, input bit p, input bit d, input bit l,
                       input logic [1:0] lv, input logic [DIV_W-1:0] dv);
    bus.start    = s;
    bus.stop     = p;
    bus.dir      = d;
    bus.load     = l;
    bus.load_val = lv;
    bus.div      = dv;
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int code_before;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 2'd0, 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    tick("post_release");

    // Up count, div=3.
    drive(1, 0, 0, 0, 2'd0, 8'd3);
    tick("up_entry");
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) tick("up");
    check("up_final_code", 32'(bus.code), 32'd0);
    check("up_final_wrap", 32'(bus.wrap), 32'd1);
    bus.stop = 1'b1;
    tick("up_stop");

    // Down count, div=0, one step per cycle.
    drive(1, 0, 1, 0, 2'd0, 8'd0);
    tick("dn_entry");
    bus.start = 1'b0;
    tick("dn_first");
    check("dn_first_code", 32'(bus.code), 32'd3);
    check("dn_first_wrap", 32'(bus.wrap), 32'd1);
    for (int i = 0; i < 7; i++) tick("dn");
    bus.stop = 1'b1;
    tick("dn_stop");

    // Async reset during RUN with code=2.
    drive(1, 0, 0, 1, 2'd2, 8'd5);
    tick("rst_load_start");
    drive(0, 0, 0, 0, 2'd0, 8'd5);
    tick("rst_run");
    tick("rst_run");
    async_reset("rst_mid_run");
    for (int i = 0; i < 3; i++) tick("rst_idle");
    check("rst_stays_idle", 32'(bus.busy), 32'd0);

    // Load at prescaler=1 during RUN.
    drive(1, 0, 0, 0, 2'd0, 8'd3);
    tick("ld_entry");
    bus.start = 1'b0;
    tick("ld_p1");
    drive(0, 0, 0, 1, 2'd2, 8'd3);
    tick("ld_load");
    check("ld_code", 32'(bus.code), 32'd2);
    check("ld_step", 32'(bus.step), 32'd0);
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) tick("ld_run");
    check("ld_next_code", 32'(bus.code), 32'd3);
    check("ld_next_step", 32'(bus.step), 32'd1);

    // Stop and start together at terminal count.
    drive(0, 0, 0, 0, 2'd0, 8'd0);
    tick("pri_run");
    code_before = m_code;
    drive(1, 1, 0, 0, 2'd0, 8'd0);
    tick("pri");
    check("pri_busy", 32'(bus.busy), 32'd0);
    check("pri_step", 32'(bus.step), 32'd0);
    check("pri_code", 32'(bus.code), 32'(code_before));

    // Divisor shrink below current count.
    drive(1, 0, 0, 0, 2'd0, 8'd10);
    tick("sh_entry");
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick("sh_count");
    bus.div = 8'd2;
    tick("sh_shrink");
    check("sh_step", 32'(bus.step), 32'd1);
    for (int i = 0; i < 3; i++) tick("sh_after");
    check("sh_period", 32'(bus.step), 32'd1);
    bus.stop = 1'b1;
    tick("sh_stop");

    // Random traffic.
    drive(0, 0, 0, 0, 2'd0, 8'd2);
    for (int i = 0; i < 3000; i++) begin
      bus.start    = ($urandom_range(7) == 0);
      bus.stop     = ($urandom_range(15) == 0);
      bus.load     = ($urandom_range(31) == 0);
      bus.load_val = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) bus.dir = ~bus.dir;
      if ($urandom_range(19) == 0) bus.div = 8'($urandom_range(5));
      tick("rnd");
      if ($urandom_range(499) == 0) async_reset("rnd_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_code_sequencer.md
DECODER_CODE_SEQUENCER -- requirements
Module: decoder_code_sequencer

Interface
REQ-001 Parameter: DIV_W, 8, width of prescaler divisor input and internal prescaler counter.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  level-sampled request to begin stepping.
REQ-005 Port: stop  input  1  level-sampled request to halt stepping.
REQ-006 Port: dir  input  1  step direction: 0 = up (+1), 1 = down (-1).
REQ-007 Port: load  input  1  synchronous load of load_val into code.
REQ-008 Port: load_val  input  2  value written to code on load.
REQ-009 Port: div  input  DIV_W  step period minus one, in clk cycles.
REQ-010 Port: code  output  2  registered 2-bit code; drives the code_in input of the downstream 2-to-4 decoder.
REQ-011 Port: step  output  1  one-cycle pulse, high in the first cycle a stepped code value is visible.
REQ-012 Port: wrap  output  1  one-cycle pulse, high with step when the step crossed 3->0 (up) or 0->3 (down).
REQ-013 Port: busy  output  1  high while FSM is in RUN.

Function
REQ-014 FSM SHALL have exactly two states: IDLE, RUN; busy SHALL equal (state == RUN), registered.
REQ-015 IDLE -> RUN when start=1 and stop=0; prescaler counter cleared to 0 on that edge.
REQ-016 RUN -> IDLE when stop=1; stop SHALL take priority over start in any state.
REQ-017 In IDLE, code and prescaler SHALL hold; step and wrap SHALL be 0.
REQ-018 In RUN, prescaler SHALL increment by 1 each cycle while prescaler < div.
REQ-019 In RUN with stop=0 and load=0, when prescaler >= div the next edge SHALL: clear prescaler, update code by dir (mod 4), assert step for one cycle.
REQ-020 Terminal test SHALL be >= (not ==) so a div reduced below the current count produces a step on the next edge, never a 2^DIV_W wrap-around.
REQ-021 div=0 SHALL yield a step every cycle in RUN; step period SHALL be div+1 cycles, first step div+1 cycles after the RUN entry edge.
REQ-022 wrap SHALL assert only coincident with step, per REQ-012; code arithmetic SHALL be 2-bit modulo.
REQ-023 load=1 in any state SHALL set code=load_val and clear prescaler on the next edge, with step=0 and wrap=0; load SHALL take priority over a coincident step.
REQ-024 load coincident with start or stop SHALL perform both actions (load plus state transition).
REQ-025 A stop coinciding with a terminal count SHALL suppress that step; code holds.
REQ-026 dir and div SHALL be sampled every cycle; changes take effect on the next evaluated step without restarting the period.
REQ-027 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, prescaler=0, code=0, step=0, wrap=0, busy=0.
REQ-029 Reset asserted mid-RUN SHALL abort immediately; after release the block SHALL remain IDLE until start.
REQ-030 Deassertion of rst_n SHALL be synchronized externally; the block SHALL not step in the first cycle after release.

Verification
REQ-031 Reset: rst_n=0 during RUN with code=2 -> same-instant code=0, step=0, wrap=0, busy=0; stays IDLE after release.
REQ-032 Up count: div=3, dir=0, start pulse -> busy=1 next cycle; code 0,1,2,3,0 changing every 4 cycles; step on each change; wrap only on 3->0.
REQ-033 Down, fast: div=0, dir=1, start -> code 3,2,1,0,3 every cycle; step continuously high; wrap on 0->3 cycles only.
REQ-034 Load mid-run: div=3, load=1, load_val=2 at prescaler=1 -> code=2 next cycle, step=0; next step 4 cycles later to code=3.
REQ-035 Priority: in RUN, start=1 and stop=1 same cycle at terminal count -> IDLE next cycle, busy=0, code unchanged, step=0.
REQ-036 Div shrink: div=10, prescaler=7, div changed to 2 -> step on the next edge, prescaler=0, no long wrap-around delay.
